count_sequence_checker: RTL and testbench
=========================================

# count_sequence_checker

Receive-side monitor for the free-running binary counter's `count` bus. It samples the incoming count value, checks that every sample is the previous value plus one (modulo 2^WIDTH), and reports lock status, mismatch pulses, a saturating error tally and a wrap tally. It sits next to the counter in the Drill designs and provides self-checking on the board or in simulation, with no external reference model.

## Interface

**Parameters**
- `WIDTH`, default 4: width of the observed count bus.
- `LOCK_N`, default 2: consecutive correct increments required to declare lock (1 to 15).
- `ERR_W`, default 8: width of the error and wrap tallies.

**Ports**
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `count_in`, in, WIDTH: observed counter value.
- `valid`, in, 1: sample enable. `count_in` is sampled only on rising edges where `valid`=1.
- `locked`, out, 1: high while the state is LOCKED.
- `err_pulse`, out, 1: one-cycle pulse on a mismatch detected while LOCKED.
- `err_count`, out, ERR_W: number of mismatches. Saturates at all-ones.
- `wrap_count`, out, ERR_W: number of max-to-0 wraps seen while LOCKED. Wraps modulo 2^ERR_W.
- `expected`, out, WIDTH: prediction for the next sample, equal to `prev`+1. Reads 0 until the first sample.

## Operation

**Internal state**
- `prev` (WIDTH): last sampled value.
- `have_prev`: set after the first valid sample.
- `good_run` (4 bits): count of consecutive correct increments.
- `state`: either HUNT or LOCKED.

**Match rule:** `count_in == prev + 1`, truncated to WIDTH bits. A stalled or repeated value is a mismatch.

**HUNT behaviour** (per valid sample)
- `have_prev`=0: capture `prev`, set `have_prev`, set `good_run`=0.
- Match: `good_run`+1. When that reaches LOCK_N, go to LOCKED and set `good_run`=0.
- Mismatch: set `good_run`=0. No `err_pulse` and no `err_count` change while hunting.
- `prev` is updated to `count_in` on every valid sample.

**LOCKED behaviour** (per valid sample)
- Match: stay in LOCKED. If `prev` is all-ones and `count_in` is 0, increment `wrap_count`.
- Mismatch:
  - `err_pulse`=1 for exactly one cycle.
  - `err_count`+1, saturating.
  - Go to HUNT with `good_run`=0 and `locked`=0.
  - `prev` becomes `count_in`, so resynchronisation starts from the new value.

**Other rules**
- `valid`=0: all state holds and `err_pulse`=0. Gaps are invisible to the checker.
- Simultaneous wrap and mismatch cannot occur, because a wrap requires a match.
- Saturation: `err_count` stops at 2^ERR_W−1. Further errors still pulse `err_pulse`.

## Timing

- All outputs are registered and reflect the sample taken on the same rising edge.
  - `locked` rises on the edge of the LOCK_N-th consecutive matching sample after the first capture.
  - `err_pulse` is high for the cycle following the mismatching edge, then returns low.
- Latency to lock is LOCK_N+1 valid samples from reset. With defaults that is 3 samples.
- Reset values: `locked`=0, `err_pulse`=0, `err_count`=0, `wrap_count`=0, `expected`=0. Internally `state`=HUNT, `have_prev`=0, `good_run`=0, `prev`=0.
- Reset mid-operation clears every output immediately, without waiting for a clock edge. The first valid sample after `rst_n` deasserts is treated as a first capture.

## Configuration

- **`CNT_CHECK_DIR_EN` defined:**
  - Adds input port `dir` (1 bit).
  - With `dir`=1 the match rule is `prev`+1. With `dir`=0 it is `prev`−1, modulo 2^WIDTH.
  - Wraps are counted on transitions from all-ones to 0 (up) or from 0 to all-ones (down).
  - A change of `dir` while LOCKED that causes a mismatch is handled as an ordinary error.
  - `expected` follows `dir`.
- **Undefined:** port `dir` is absent and the checker checks up-counting only.

## Test plan

With WIDTH=4, LOCK_N=2, ERR_W=8 unless stated:

1. Reset, then `valid`=1 with 0,1,2 → `locked`=1 after the third edge; `expected`=3; `err_count`=0.
2. Locked sequence ...,14,15,0,1 → `wrap_count` goes 0→1 on the 15→0 edge; `err_pulse` stays 0.
3. Locked at 5, then feed 7 → `err_pulse` high for one cycle, `err_count`=1, `locked`=0. Then feed 8,9 → `locked`=1 again.
4. ERR_W=2, four lock/mismatch cycles → `err_count` stays at 3 and `err_pulse` still fires each time.
5. Locked at 9, then `valid`=0 for 3 cycles with `count_in`=3 → no output change. Resume with 10 → no error.
6. `rst_n` driven low asynchronously between edges while locked → all outputs 0 before the next `clk` edge. Then release and feed 4,5,6 → relock.
7. With `CNT_CHECK_DIR_EN` and `dir`=0, feed 1,0,15 → locked, and `wrap_count`=1.

Source files
------------

// File: rtl/count_seq_if.sv
// Bundles the observed count bus, its sample enable and the checker's status outputs.
// With CNT_CHECK_DIR_EN defined, a direction input is also carried.
interface count_seq_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic [WIDTH-1:0] count_in;
  logic             valid;
`ifdef CNT_CHECK_DIR_EN
  logic             dir;
`endif
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [ERR_W-1:0] wrap_count;
  logic [WIDTH-1:0] expected;

`ifdef CNT_CHECK_DIR_EN
  modport master (
    output count_in, valid, dir,
    input  locked, err_pulse, err_count, wrap_count, expected
  );
  modport slave (
    input  count_in, valid, dir,
    output locked, err_pulse, err_count, wrap_count, expected
  );
`else
  modport master (
    output count_in, valid,
    input  locked, err_pulse, err_count, wrap_count, expected
  );
  modport slave (
    input  count_in, valid,
    output locked, err_pulse, err_count, wrap_count, expected
  );
`endif
endinterface

// File: rtl/count_sequence_checker.sv
// Receive-side monitor that checks a count bus increments by one per valid sample.
// Define CNT_CHECK_DIR_EN to add a dir input selecting up (1) or down (0) counting.
module count_sequence_checker #(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 2,
  parameter int ERR_W  = 8
) (
  input logic        clk,
  input logic        rst_n,
  count_seq_if.slave bus
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_N);
  localparam logic [WIDTH-1:0] ALL_ONES    = '1;
  localparam logic [WIDTH-1:0] STEP_ONE    = 1;
  localparam logic [ERR_W-1:0] ERR_ONE     = 1;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_ONE;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [3:0]       good_run_q, good_run_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [ERR_W-1:0] wrap_count_q, wrap_count_d;

  logic             up;
  logic [WIDTH-1:0] pred;
  logic             match;
  logic             wrap_edge;
  logic [3:0]       good_run_inc;

`ifdef CNT_CHECK_DIR_EN
  assign up = bus.dir;
`else
  assign up = 1'b1;
`endif

  assign pred         = up ? (prev_q + STEP_ONE) : (prev_q - STEP_ONE);
  assign match        = (bus.count_in == pred);
  assign wrap_edge    = up ? (prev_q == ALL_ONES) : (prev_q == '0);
  assign good_run_inc = good_run_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    have_prev_d  = have_prev_q;
    good_run_d   = good_run_q;
    err_pulse_d  = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;

    if (bus.valid) begin
      prev_d = bus.count_in;
      unique case (state_q)
        HUNT: begin
          if (!have_prev_q) begin
            have_prev_d = 1'b1;
            good_run_d  = 4'd0;
          end else if (match) begin
            if (good_run_inc == LOCK_TARGET) begin
              state_d    = LOCKED;
              good_run_d = 4'd0;
              // The locking sample already counts as seen while locked.
              if (wrap_edge) wrap_count_d = wrap_count_q + ERR_ONE;
            end else begin
              good_run_d = good_run_inc;
            end
          end else begin
            good_run_d = 4'd0;
          end
        end
        LOCKED: begin
          if (match) begin
            if (wrap_edge) wrap_count_d = wrap_count_q + ERR_ONE;
          end else begin
            err_pulse_d = 1'b1;
            err_count_d = sat_inc(err_count_q);
            state_d     = HUNT;
            good_run_d  = 4'd0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      prev_q       <= '0;
      have_prev_q  <= 1'b0;
      good_run_q   <= 4'd0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      have_prev_q  <= have_prev_d;
      good_run_q   <= good_run_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  // Prediction is derived from the registered previous sample, so it is 0 until the first capture.
  assign bus.locked     = (state_q == LOCKED);
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_count  = err_count_q;
  assign bus.wrap_count = wrap_count_q;
  assign bus.expected   = have_prev_q ? pred : '0;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench: a vector table for the main checker plus short hand sequences
// for asynchronous reset, error-tally saturation and (when enabled) down counting.
module tb_count_sequence_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  count_seq_if #(.WIDTH(4), .ERR_W(8)) if_a ();
  count_seq_if #(.WIDTH(4), .ERR_W(2)) if_b ();

  count_sequence_checker #(.WIDTH(4), .LOCK_N(2), .ERR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  count_sequence_checker #(.WIDTH(4), .LOCK_N(2), .ERR_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  typedef struct {
    logic       v;
    logic [3:0] c;
    logic       l;
    logic       ep;
    logic [7:0] e;
    logic [7:0] w;
    logic [3:0] x;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [3:0] c);
    @(negedge clk);
    if (sel == 0) begin
      if_a.valid    = v;
      if_a.count_in = c;
    end else begin
      if_b.valid    = v;
      if_b.count_in = c;
    end
    @(posedge clk);
    #1;
    if (sel == 0) if_a.valid = 1'b0;
    else          if_b.valid = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic l, input logic ep,
                       input logic [7:0] e, input logic [7:0] w, input logic [3:0] x);
    chk({tag, "_locked"},     32'(if_a.locked),     32'(l));
    chk({tag, "_err_pulse"},  32'(if_a.err_pulse),  32'(ep));
    chk({tag, "_err_count"},  32'(if_a.err_count),  32'(e));
    chk({tag, "_wrap_count"}, 32'(if_a.wrap_count), 32'(w));
    chk({tag, "_expected"},   32'(if_a.expected),   32'(x));
  endtask

  initial begin
    logic [3:0] p;
    logic [3:0] bad;
    logic [1:0] exp_err;

    if_a.valid = 1'b0; if_a.count_in = 4'd0;
    if_b.valid = 1'b0; if_b.count_in = 4'd0;
`ifdef CNT_CHECK_DIR_EN
    if_a.dir = 1'b1;
    if_b.dir = 1'b1;
`endif

    vecs.push_back('{1'b1, 4'd12, 1'b0, 1'b0, 8'd0, 8'd0, 4'd13});
    vecs.push_back('{1'b1, 4'd13, 1'b0, 1'b0, 8'd0, 8'd0, 4'd14});
    vecs.push_back('{1'b1, 4'd14, 1'b1, 1'b0, 8'd0, 8'd0, 4'd15});
    vecs.push_back('{1'b1, 4'd15, 1'b1, 1'b0, 8'd0, 8'd0, 4'd0});
    vecs.push_back('{1'b1, 4'd0,  1'b1, 1'b0, 8'd0, 8'd1, 4'd1});
    vecs.push_back('{1'b1, 4'd1,  1'b1, 1'b0, 8'd0, 8'd1, 4'd2});
    vecs.push_back('{1'b1, 4'd2,  1'b1, 1'b0, 8'd0, 8'd1, 4'd3});
    vecs.push_back('{1'b1, 4'd3,  1'b1, 1'b0, 8'd0, 8'd1, 4'd4});
    vecs.push_back('{1'b1, 4'd4,  1'b1, 1'b0, 8'd0, 8'd1, 4'd5});
    vecs.push_back('{1'b1, 4'd5,  1'b1, 1'b0, 8'd0, 8'd1, 4'd6});
    vecs.push_back('{1'b1, 4'd7,  1'b0, 1'b1, 8'd1, 8'd1, 4'd8});
    vecs.push_back('{1'b1, 4'd8,  1'b0, 1'b0, 8'd1, 8'd1, 4'd9});
    vecs.push_back('{1'b1, 4'd9,  1'b1, 1'b0, 8'd1, 8'd1, 4'd10});
    vecs.push_back('{1'b0, 4'd3,  1'b1, 1'b0, 8'd1, 8'd1, 4'd10});
    vecs.push_back('{1'b0, 4'd3,  1'b1, 1'b0, 8'd1, 8'd1, 4'd10});
    vecs.push_back('{1'b0, 4'd3,  1'b1, 1'b0, 8'd1, 8'd1, 4'd10});
    vecs.push_back('{1'b1, 4'd10, 1'b1, 1'b0, 8'd1, 8'd1, 4'd11});
    vecs.push_back('{1'b1, 4'd10, 1'b0, 1'b1, 8'd2, 8'd1, 4'd11});
    vecs.push_back('{1'b0, 4'd3,  1'b0, 1'b0, 8'd2, 8'd1, 4'd11});
    vecs.push_back('{1'b1, 4'd11, 1'b0, 1'b0, 8'd2, 8'd1, 4'd12});
    vecs.push_back('{1'b1, 4'd12, 1'b1, 1'b0, 8'd2, 8'd1, 4'd13});

    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(0, vecs[i].v, vecs[i].c);
      chk_a($sformatf("vec%0d", i), vecs[i].l, vecs[i].ep, vecs[i].e, vecs[i].w, vecs[i].x);
    end

    // Asynchronous reset between edges while locked, then relock from a fresh capture.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_a("async_rst", 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 4'd4);
    chk_a("relock4", 1'b0, 1'b0, 8'd0, 8'd0, 4'd5);
    drive(0, 1'b1, 4'd5);
    chk_a("relock5", 1'b0, 1'b0, 8'd0, 8'd0, 4'd6);
    drive(0, 1'b1, 4'd6);
    chk_a("relock6", 1'b1, 1'b0, 8'd0, 8'd0, 4'd7);

    // Two-bit error tally saturates while err_pulse keeps firing.
    drive(1, 1'b1, 4'd0);
    p = 4'd0;
    exp_err = 2'd0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 1'b1, p + 4'd1);
      drive(1, 1'b1, p + 4'd2);
      chk($sformatf("sat%0d_locked", k), 32'(if_b.locked), 32'd1);
      bad = p + 4'd7;
      drive(1, 1'b1, bad);
      if (exp_err != 2'd3) exp_err = exp_err + 2'd1;
      chk($sformatf("sat%0d_err_pulse", k), 32'(if_b.err_pulse), 32'd1);
      chk($sformatf("sat%0d_err_count", k), 32'(if_b.err_count), 32'(exp_err));
      chk($sformatf("sat%0d_unlocked", k), 32'(if_b.locked), 32'd0);
      p = bad;
    end
    drive(1, 1'b0, 4'd0);
    chk("sat_pulse_clear", 32'(if_b.err_pulse), 32'd0);
    chk("sat_hold", 32'(if_b.err_count), 32'd3);

`ifdef CNT_CHECK_DIR_EN
    // Down counting through 0 -> 15 counts as a wrap on the locking sample.
    @(negedge clk);
    rst_n = 1'b0;
    if_a.dir = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 4'd1);
    chk_a("down1", 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    drive(0, 1'b1, 4'd0);
    chk_a("down0", 1'b0, 1'b0, 8'd0, 8'd0, 4'd15);
    drive(0, 1'b1, 4'd15);
    chk_a("down15", 1'b1, 1'b0, 8'd0, 8'd1, 4'd14);
    drive(0, 1'b1, 4'd14);
    chk_a("down14", 1'b1, 1'b0, 8'd0, 8'd1, 4'd13);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
